d_ext_pipe: RTL and testbench
=============================

// Module: d_ext_pipe
// PURPOSE
//  Parametrised, pipelined immediate/target generator for the ID->EX path. It generalises the
//  combinational extender with configurable widths and stage count, a valid/ready handshake,
//  flush and an illegal-op flag. It takes instr fields + PC from decode and delivers the
//  registered immediate/target to EX after DEPTH cycles.
// PARAMETERS
//  DATA_W  32  datapath / PC width (>= 32)
//  IMM_W   16  short immediate width
//  IDX_W   26  jump index width (DATA_W-6 when DATA_W=32)
//  OP_W    4   extOp code width
//  DEPTH   1   register stages, 1..4
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  flush        in   1       sync kill of all in-flight entries
//  in_valid     in   1       input beat valid
//  in_ready     out  1       block accepts a beat this cycle
//  in_imm       in   IMM_W   instr short immediate
//  in_idx       in   IDX_W   instr jump index
//  in_op        in   OP_W    extension op code
//  in_pc        in   DATA_W  PC of the instruction
//  out_valid    out  1       output beat valid
//  out_ready    in   1       consumer accepts beat
//  out_imm      out  DATA_W  extended immediate / target
//  out_pc       out  DATA_W  PC carried alongside
//  out_illegal  out  1       in_op was not a defined code
//  out_misalign out  1       target misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - Op codes: 0 NOPE->0; 1 SIGN->sext(imm); 2 BRANCH->pc+4+(sext(imm)<<2);
//    3 LUI->imm<<16 (low zeros, upper truncated to DATA_W); 4 JUMP->{pc[top4],idx,2'b00};
//    5 ZERO->zext(imm); 6 SIGN_SH2->sext(imm)<<2 (new). Codes 7..2^OP_W-1 -> imm 0, illegal=1.
//  - BRANCH arithmetic mod 2^DATA_W; wrap-around silently (pc=FFFF_FFFC, imm=0 -> 0000_0000).
//  - Computation combinational on inputs, captured into stage 0; stages 1..DEPTH-1 are plain
//    shift registers. Each stage holds {valid, imm, pc, illegal, misalign}.
//  - advance = !out_valid | out_ready; in_ready = advance (global, no bubble collapsing).
//  - When advance: every stage shifts one place; stage0.valid <= in_valid. When !advance: all
//    stages hold, in_ready=0, input ignored. Latency: DEPTH cycles when out_ready stays 1.
//  - Throughput 1 beat/cycle with out_ready=1; outputs stable while out_valid & !out_ready.
//  - flush (priority over everything): all valid bits <= 0 next edge, same-cycle input beat
//    dropped, data fields don't-care; in_ready unaffected by flush.
//  - out_* are stage DEPTH-1 contents; out_imm/out_pc/flags meaningful only with out_valid.
//  - Reset (async, reset=0): all valid=0, all data/flags=0 -> out_valid=0, out_imm=0,
//    out_pc=0, out_illegal=0, out_misalign=0; in_ready=1 once out_valid=0. Reset mid-stream
//    discards all beats; first edge after release may accept a beat.
//  - DEPTH outside 1..4: elaboration error ($error in generate).
// CONFIGURATION
//  EXT_ALIGN_CHECK_EN defined: out_misalign=1 for BRANCH/JUMP beats whose in_pc[1:0]!=0,
//    registered and pipelined with the beat; the imm value is still computed.
//  EXT_ALIGN_CHECK_EN undefined: out_misalign tied 0, no check logic.
// TESTING
//  1 reset=0 then release, out_ready=1 -> out_valid=0, in_ready=1, all outputs 0.
//  2 DEPTH=1, op=2, pc=0000_3000, imm=FFFF -> next cycle out_imm=0000_3000, out_valid=1.
//  3 op=4, pc=8000_0000, idx=000_0010 -> out_imm=8000_0040; op=3, imm=1234 -> 1234_0000.
//  4 DEPTH=3, out_ready=0 after 3 beats -> in_ready=0, outputs frozen; on release beats exit in order.
//  5 flush with in_valid=1 and 2 beats in flight -> next cycle out_valid=0, no beat emerges.
//  6 op=F -> out_imm=0, out_illegal=1; with EXT_ALIGN_CHECK_EN, op=2, pc=0000_3002 -> out_misalign=1.

Source files
------------

// File: rtl/d_ext_pipe.sv
// d_ext_pipe: pipelined immediate/branch-target generator for the ID->EX path, DEPTH register stages.
// Optional feature macro EXT_ALIGN_CHECK_EN adds a pipelined BRANCH/JUMP PC misalignment flag.
`default_nettype none

module d_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int IDX_W  = 26,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic              out_illegal,
  output logic              out_misalign
);

  // Clamped so the arrays stay legal while the elaboration error below reports a bad DEPTH.
  localparam int D = (DEPTH < 1) ? 1 : ((DEPTH > 4) ? 4 : DEPTH);

  localparam logic [OP_W-1:0] OP_NOPE     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SIGN     = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BRANCH   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LUI      = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JUMP     = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ZERO     = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SIGN_SH2 = OP_W'(6);

  localparam logic [DATA_W-1:0] TOP4_MASK = {4'hF, {(DATA_W-4){1'b0}}};

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_err
      $error("d_ext_pipe: DEPTH must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] sext_w;
  logic [DATA_W-1:0] zext_w;
  logic [DATA_W-1:0] imm_d;
  logic              illegal_d;
  logic              advance_w;

  assign sext_w = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign zext_w = DATA_W'(in_imm);

  always_comb begin
    imm_d     = '0;
    illegal_d = 1'b0;
    case (in_op)
      OP_NOPE:     imm_d = '0;
      OP_SIGN:     imm_d = sext_w;
      OP_BRANCH:   imm_d = in_pc + DATA_W'(4) + (sext_w << 2);
      OP_LUI:      imm_d = zext_w << 16;
      OP_JUMP:     imm_d = (in_pc & TOP4_MASK) | (DATA_W'(in_idx) << 2);
      OP_ZERO:     imm_d = zext_w;
      OP_SIGN_SH2: imm_d = sext_w << 2;
      default:     illegal_d = 1'b1;
    endcase
  end

  logic              valid_q   [D];
  logic [DATA_W-1:0] imm_q     [D];
  logic [DATA_W-1:0] pc_q      [D];
  logic              illegal_q [D];

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign advance_w = !out_valid || out_ready;
  assign in_ready  = advance_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) valid_q[i] <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < D; i++) valid_q[i] <= 1'b0;
    end else if (advance_w) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < D; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        imm_q[i]     <= '0;
        pc_q[i]      <= '0;
        illegal_q[i] <= 1'b0;
      end
    end else if (advance_w) begin
      imm_q[0]     <= imm_d;
      pc_q[0]      <= in_pc;
      illegal_q[0] <= illegal_d;
      for (int i = 1; i < D; i++) begin
        imm_q[i]     <= imm_q[i-1];
        pc_q[i]      <= pc_q[i-1];
        illegal_q[i] <= illegal_q[i-1];
      end
    end
  end

`ifdef EXT_ALIGN_CHECK_EN
  logic misalign_d;
  logic misalign_q [D];

  assign misalign_d = ((in_op == OP_BRANCH) || (in_op == OP_JUMP)) && (in_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) misalign_q[i] <= 1'b0;
    end else if (advance_w) begin
      misalign_q[0] <= misalign_d;
      for (int i = 1; i < D; i++) misalign_q[i] <= misalign_q[i-1];
    end
  end

  assign out_misalign = misalign_q[D-1];
`else
  assign out_misalign = 1'b0;
`endif

  assign out_valid   = valid_q[D-1];
  assign out_imm     = imm_q[D-1];
  assign out_pc      = pc_q[D-1];
  assign out_illegal = illegal_q[D-1];

endmodule

`default_nettype wire

// File: tb/tb_d_ext_pipe.sv
// tb_d_ext_pipe: drives a DEPTH=1 and a DEPTH=3 instance from shared inputs; scoreboards both.
`default_nettype none

module tb_d_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_imm;
  logic [25:0] in_idx;
  logic [3:0]  in_op;
  logic [31:0] in_pc;

  logic        in_ready1, out_valid1, out_illegal1, out_misalign1;
  logic [31:0] out_imm1, out_pc1;
  logic        in_ready3, out_valid3, out_illegal3, out_misalign3;
  logic [31:0] out_imm3, out_pc3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
    logic        mis;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  d_ext_pipe #(.DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_imm(in_imm), .in_idx(in_idx), .in_op(in_op), .in_pc(in_pc),
    .out_valid(out_valid1), .out_ready(out_ready), .out_imm(out_imm1), .out_pc(out_pc1),
    .out_illegal(out_illegal1), .out_misalign(out_misalign1)
  );

  d_ext_pipe #(.DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_imm(in_imm), .in_idx(in_idx), .in_op(in_op), .in_pc(in_pc),
    .out_valid(out_valid3), .out_ready(out_ready), .out_imm(out_imm3), .out_pc(out_pc3),
    .out_illegal(out_illegal3), .out_misalign(out_misalign3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t f_exp(input logic [3:0] op, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic [31:0] pc);
    exp_t        r;
    logic [31:0] s;
    s     = {{16{imm[15]}}, imm};
    r.pc  = pc;
    r.ill = 1'b0;
    r.imm = 32'h0;
    case (op)
      4'd0:    r.imm = 32'h0;
      4'd1:    r.imm = s;
      4'd2:    r.imm = pc + 32'd4 + {s[29:0], 2'b00};
      4'd3:    r.imm = {imm, 16'h0000};
      4'd4:    r.imm = {pc[31:28], idx, 2'b00};
      4'd5:    r.imm = {16'h0000, imm};
      4'd6:    r.imm = {s[29:0], 2'b00};
      default: r.ill = 1'b1;
    endcase
`ifdef EXT_ALIGN_CHECK_EN
    r.mis = ((op == 4'd2) || (op == 4'd4)) && (pc[1:0] != 2'b00);
`else
    r.mis = 1'b0;
`endif
    return r;
  endfunction

  // Scoreboards sample mid-cycle, ahead of the edge that performs each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) q1.delete();
    else begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("u1 spurious out_valid", {31'b0, out_valid1}, 32'h0);
        else begin
          e = q1.pop_front();
          chk("u1 out_imm", out_imm1, e.imm);
          chk("u1 out_pc", out_pc1, e.pc);
          chk("u1 out_illegal", {31'b0, out_illegal1}, {31'b0, e.ill});
          chk("u1 out_misalign", {31'b0, out_misalign1}, {31'b0, e.mis});
        end
      end
      if (flush) q1.delete();
      else if (in_valid && in_ready1) q1.push_back(f_exp(in_op, in_imm, in_idx, in_pc));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) q3.delete();
    else begin
      if (out_valid3 && out_ready) begin
        if (q3.size() == 0) chk("u3 spurious out_valid", {31'b0, out_valid3}, 32'h0);
        else begin
          e = q3.pop_front();
          chk("u3 out_imm", out_imm3, e.imm);
          chk("u3 out_pc", out_pc3, e.pc);
          chk("u3 out_illegal", {31'b0, out_illegal3}, {31'b0, e.ill});
          chk("u3 out_misalign", {31'b0, out_misalign3}, {31'b0, e.mis});
        end
      end
      if (flush) q3.delete();
      else if (in_valid && in_ready3) q3.push_back(f_exp(in_op, in_imm, in_idx, in_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] pc);
    in_op    = op;
    in_imm   = imm;
    in_idx   = idx;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_imm = '0; in_idx = '0; in_pc = '0;
    repeat (3) step();
    chk("in reset out_valid3", {31'b0, out_valid3}, 32'h0);
    reset = 1'b1;
    step();

    // Reset state
    chk("rst out_valid1", {31'b0, out_valid1}, 32'h0);
    chk("rst out_valid3", {31'b0, out_valid3}, 32'h0);
    chk("rst in_ready1", {31'b0, in_ready1}, 32'h1);
    chk("rst in_ready3", {31'b0, in_ready3}, 32'h1);
    chk("rst out_imm3", out_imm3, 32'h0);
    chk("rst out_pc3", out_pc3, 32'h0);
    chk("rst out_illegal3", {31'b0, out_illegal3}, 32'h0);
    chk("rst out_misalign3", {31'b0, out_misalign3}, 32'h0);

    // BRANCH with negative offset, latency of both depths
    send(4'd2, 16'hFFFF, 26'h0, 32'h0000_3000);
    chk("branch u1 out_valid", {31'b0, out_valid1}, 32'h1);
    chk("branch u1 out_imm", out_imm1, 32'h0000_3000);
    chk("branch u3 not yet valid", {31'b0, out_valid3}, 32'h0);
    step();
    chk("branch u3 not yet valid 2", {31'b0, out_valid3}, 32'h0);
    step();
    chk("branch u3 out_valid", {31'b0, out_valid3}, 32'h1);
    chk("branch u3 out_imm", out_imm3, 32'h0000_3000);
    step();

    // Op table sweep
    send(4'd4, 16'h0, 26'h000_0010, 32'h8000_0000);
    chk("jump out_imm", out_imm1, 32'h8000_0040);
    send(4'd3, 16'h1234, 26'h0, 32'h0000_0100);
    chk("lui out_imm", out_imm1, 32'h1234_0000);
    send(4'd1, 16'h8000, 26'h0, 32'h0000_0104);
    chk("sign out_imm", out_imm1, 32'hFFFF_8000);
    send(4'd5, 16'h8000, 26'h0, 32'h0000_0108);
    chk("zero out_imm", out_imm1, 32'h0000_8000);
    send(4'd6, 16'hFFFF, 26'h0, 32'h0000_010C);
    chk("sign_sh2 out_imm", out_imm1, 32'hFFFF_FFFC);
    send(4'd0, 16'h1234, 26'h3FF_FFFF, 32'h0000_0110);
    chk("nope out_imm", out_imm1, 32'h0);
    send(4'hF, 16'h1234, 26'h0, 32'h0000_0114);
    chk("illegal F out_imm", out_imm1, 32'h0);
    chk("illegal F flag", {31'b0, out_illegal1}, 32'h1);
    send(4'd7, 16'h5555, 26'h0, 32'h0000_0118);
    chk("illegal 7 flag", {31'b0, out_illegal1}, 32'h1);
    send(4'd2, 16'h0000, 26'h0, 32'hFFFF_FFFC);
    chk("branch wrap out_imm", out_imm1, 32'h0000_0000);
    send(4'd2, 16'h0000, 26'h0, 32'h0000_3002);
    chk("branch misaligned out_imm", out_imm1, 32'h0000_3006);
`ifdef EXT_ALIGN_CHECK_EN
    chk("misalign flag", {31'b0, out_misalign1}, 32'h1);
`else
    chk("misalign flag", {31'b0, out_misalign1}, 32'h0);
`endif
    send(4'd4, 16'h0, 26'h123_4567, 32'h7000_0001);
    repeat (4) step();

    // Backpressure on the DEPTH=3 pipe
    send(4'd1, 16'h0001, 26'h0, 32'h0000_0A00);
    send(4'd1, 16'h0002, 26'h0, 32'h0000_0A04);
    send(4'd1, 16'h0003, 26'h0, 32'h0000_0A08);
    out_ready = 1'b0;
    #1;
    chk("stall u3 in_ready", {31'b0, in_ready3}, 32'h0);
    chk("stall u3 out_valid", {31'b0, out_valid3}, 32'h1);
    chk("stall u3 out_imm", out_imm3, 32'h0000_0001);
    send(4'd1, 16'h0004, 26'h0, 32'h0000_0A0C);
    chk("stall u3 frozen imm", out_imm3, 32'h0000_0001);
    chk("stall u3 frozen pc", out_pc3, 32'h0000_0A00);
    chk("stall u1 frozen imm", out_imm1, 32'h0000_0003);
    repeat (2) step();
    chk("stall u3 frozen imm 2", out_imm3, 32'h0000_0001);
    chk("stall u3 in_ready 2", {31'b0, in_ready3}, 32'h0);
    out_ready = 1'b1;
    step();
    chk("release u3 second beat", out_imm3, 32'h0000_0002);
    repeat (2) step();
    chk("release u3 drained", {31'b0, out_valid3}, 32'h0);
    chk("release u3 queue empty", q3.size(), 32'h0);
    repeat (2) step();

    // Flush with two beats in flight and a beat offered
    send(4'd1, 16'h0011, 26'h0, 32'h0000_0B00);
    send(4'd1, 16'h0022, 26'h0, 32'h0000_0B04);
    in_op = 4'd1; in_imm = 16'h0033; in_pc = 32'h0000_0B08;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush in_ready3", {31'b0, in_ready3}, 32'h1);
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush u3 out_valid", {31'b0, out_valid3}, 32'h0);
    chk("flush u1 out_valid", {31'b0, out_valid1}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post flush u3 out_valid", {31'b0, out_valid3}, 32'h0);
    end

    // Pipe still works after flush
    send(4'd3, 16'hABCD, 26'h0, 32'h0000_0C00);
    repeat (4) step();
    chk("final u1 queue empty", q1.size(), 32'h0);
    chk("final u3 queue empty", q3.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
